// File: rtl/vp_line_scheduler.sv
// Line fetch sequencer: pulls COLUMNS char/attr words per scanline into a small FIFO
// and hands one to the pipeline per char_strobe. Optional macro: VP_LINE_SCHEDULER_UNDERRUN_COUNT_EN.
module vp_line_scheduler #(
    parameter int unsigned COLUMNS     = 80,
    parameter int unsigned CHAR_HEIGHT = 20,
    parameter int unsigned FIFO_DEPTH  = 4,
    localparam int unsigned ADDR_W     = 23,
    localparam int unsigned DATA_W     = 32,
    localparam int unsigned ROW_W      = 5,
    localparam int unsigned FRM_W      = 7,
    localparam int unsigned UCNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic              char_strobe,
    input  logic [ADDR_W-1:0] base_address,
    output logic              mem_request,
    output logic [ADDR_W-1:0] mem_address,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] charattr,
    output logic [ROW_W-1:0]  char_row,
    output logic [FRM_W-1:0]  frame_count,
    output logic              enabled,
    output logic              busy,
    output logic              underrun,
    output logic [UCNT_W-1:0] underrun_count
);

    localparam int unsigned COL_W = 7;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLUMNS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(CHAR_HEIGHT - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [ADDR_W-1:0]   r_row_addr;
    logic [ROW_W-1:0]    r_char_row;
    logic [COL_W-1:0]    r_col;
    logic [FRM_W-1:0]    r_frame_count;
    logic                r_first_line;

    logic [DATA_W-1:0]   r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_next;

    logic [DATA_W-1:0]   r_charattr;
    logic                r_enabled;
    logic                r_underrun;

    logic                w_flush;
    logic                w_push;
    logic                w_pop;
    logic                w_empty;
    logic                w_req;
    logic                w_busy;

    // Either pulse discards the current line's buffered words and any in-flight ack.
    assign w_flush = frame_start | line_start;
    assign w_empty = (r_count == '0);
    assign w_push  = (r_state == ST_REQ) & mem_ack & ~w_flush;
    assign w_pop   = char_strobe & ~w_empty;

    always_comb begin
        w_count_next = r_count;
        if (w_flush) begin
            w_count_next = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + CNT_W'(1);
                2'b01:   w_count_next = r_count - CNT_W'(1);
                default: w_count_next = r_count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; a line_start always (re)starts a fetch, even alongside frame_start
    always_comb begin
        w_state_next = r_state;
        if (line_start) begin
            w_state_next = ST_REQ;
        end else if (frame_start) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (w_push) begin
                        if (r_col == LAST_COL) begin
                            w_state_next = ST_IDLE;
                        end else if (w_count_next == FULL_CNT) begin
                            w_state_next = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_count_next < FULL_CNT) begin
                        w_state_next = ST_REQ;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    // FSM outputs, decoded from the state register only
    always_comb begin
        w_req  = 1'b0;
        w_busy = 1'b0;
        case (r_state)
            ST_REQ: begin
                w_req  = 1'b1;
                w_busy = 1'b1;
            end
            ST_WAIT: w_busy = 1'b1;
            default: begin
                w_req  = 1'b0;
                w_busy = 1'b0;
            end
        endcase
    end

    // Text row / glyph row tracking; the first line of a frame does not advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row_addr    <= '0;
            r_char_row    <= '0;
            r_first_line  <= 1'b1;
            r_frame_count <= '0;
        end else if (frame_start) begin
            r_row_addr    <= base_address;
            r_char_row    <= '0;
            r_first_line  <= ~line_start;
            r_frame_count <= r_frame_count + FRM_W'(1);
        end else if (line_start) begin
            r_first_line <= 1'b0;
            if (!r_first_line) begin
                if (r_char_row == LAST_ROW) begin
                    r_char_row <= '0;
                    r_row_addr <= r_row_addr + ADDR_W'(COLUMNS);
                end else begin
                    r_char_row <= r_char_row + ROW_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col <= '0;
        end else if (w_flush) begin
            r_col <= '0;
        end else if (w_push) begin
            r_col <= r_col + COL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= mem_data;
        end
    end

    // A pop in the same cycle as a flush still delivers the pre-flush head word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_charattr <= '0;
            r_enabled  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_enabled <= 1'b0;
            if (char_strobe) begin
                if (w_empty) begin
                    r_charattr <= '0;
                end else begin
                    r_charattr <= r_fifo_mem[r_rd_ptr];
                    r_enabled  <= 1'b1;
                end
            end
            if (frame_start) begin
                r_underrun <= 1'b0;
            end else if (char_strobe && w_empty) begin
                r_underrun <= 1'b1;
            end
        end
    end

`ifdef VP_LINE_SCHEDULER_UNDERRUN_COUNT_EN
    logic [UCNT_W-1:0] r_underrun_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_underrun_count <= '0;
        end else if (frame_start) begin
            r_underrun_count <= '0;
        end else if (char_strobe && w_empty && (r_underrun_count != '1)) begin
            r_underrun_count <= r_underrun_count + UCNT_W'(1);
        end
    end

    assign underrun_count = r_underrun_count;
`else
    assign underrun_count = '0;
`endif

    assign mem_request = w_req;
    assign busy        = w_busy;
    assign mem_address = r_row_addr + ADDR_W'(r_col);
    assign charattr    = r_charattr;
    assign char_row    = r_char_row;
    assign frame_count = r_frame_count;
    assign enabled     = r_enabled;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_vp_line_scheduler.sv
// Bench for vp_line_scheduler: directed vector table, corner sequences, and random traffic
// checked against a queue-based model of the fetch/consume rules.
module tb_vp_line_scheduler;

    localparam int COLS  = 80;
    localparam int CH    = 20;
    localparam int DEPTH = 4;
    localparam int NV    = 17;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        line_start;
    logic        char_strobe;
    logic [22:0] base_address;
    logic        mem_request;
    logic [22:0] mem_address;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [31:0] charattr;
    logic [4:0]  char_row;
    logic [6:0]  frame_count;
    logic        enabled;
    logic        busy;
    logic        underrun;
    logic [7:0]  underrun_count;

    int n_tests = 0;
    int n_fail  = 0;

    vp_line_scheduler #(
        .COLUMNS    (COLS),
        .CHAR_HEIGHT(CH),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .line_start    (line_start),
        .char_strobe   (char_strobe),
        .base_address  (base_address),
        .mem_request   (mem_request),
        .mem_address   (mem_address),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data),
        .charattr      (charattr),
        .char_row      (char_row),
        .frame_count   (frame_count),
        .enabled       (enabled),
        .busy          (busy),
        .underrun      (underrun),
        .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    // Reference model: words fetched this line but not yet consumed, plus line/frame counters.
    logic [31:0] m_q[$];
    logic [22:0] m_base;
    int          m_line;
    int          m_acks;
    bit          m_active;
    logic [6:0]  m_fc;
    logic        m_en;
    logic [31:0] m_ca;
    logic        m_und;
    logic [7:0]  m_ucnt;
    logic [22:0] cur_base;

    typedef struct packed {
        logic        fs;
        logic        ls;
        logic        cs;
        logic        ack;
        logic        req;
        logic        bsy;
        logic        en;
        logic        und;
        logic [22:0] addr;
        logic [31:0] ca;
        logic [4:0]  row;
        logic [6:0]  fc;
    } vec_t;

    vec_t tv [NV];

    function automatic logic [31:0] word_for(input logic [22:0] a);
        return {9'h1A5, a};
    endfunction

    function automatic bit m_req();
        return m_active && (m_acks < COLS) && (m_q.size() < DEPTH);
    endfunction

    function automatic bit m_busy();
        return m_active && (m_acks < COLS);
    endfunction

    function automatic int m_idx();
        return (m_line < 0) ? 0 : m_line;
    endfunction

    function automatic logic [22:0] m_row_addr();
        return m_base + 23'((m_idx() / CH) * COLS);
    endfunction

    function automatic logic [22:0] m_addr();
        return m_row_addr() + 23'(m_acks);
    endfunction

    function automatic logic [4:0] m_row();
        return 5'(m_idx() % CH);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_base   = '0;
        m_line   = -1;
        m_acks   = 0;
        m_active = 1'b0;
        m_fc     = '0;
        m_en     = 1'b0;
        m_ca     = '0;
        m_und    = 1'b0;
        m_ucnt   = '0;
    endtask

    // Applies one clock edge's worth of the rules to the model.
    task automatic model_step(input logic fs, input logic ls, input logic cs, input logic ack,
                              input logic [31:0] data, input logic [22:0] base);
        bit accept;
        accept = ack && m_req() && !fs && !ls;
        m_en = 1'b0;
        if (cs) begin
            if (m_q.size() > 0) begin
                m_ca = m_q.pop_front();
                m_en = 1'b1;
            end else begin
                m_ca  = '0;
                m_und = 1'b1;
`ifdef VP_LINE_SCHEDULER_UNDERRUN_COUNT_EN
                if (m_ucnt != 8'hFF) m_ucnt = m_ucnt + 8'd1;
`endif
            end
        end
        if (accept) begin
            m_q.push_back(data);
            m_acks++;
        end
        if (fs) begin
            m_base   = base;
            m_line   = -1;
            m_fc     = m_fc + 7'd1;
            m_und    = 1'b0;
            m_ucnt   = '0;
            m_active = 1'b0;
            m_q.delete();
        end
        if (ls) begin
            m_line++;
            m_acks   = 0;
            m_active = 1'b1;
            m_q.delete();
        end
    endtask

    task automatic check_model();
        check("mem_request", 32'(mem_request), 32'(m_req()));
        check("busy", 32'(busy), 32'(m_busy()));
        if (m_req()) check("mem_address", 32'(mem_address), 32'(m_addr()));
        check("enabled", 32'(enabled), 32'(m_en));
        check("charattr", charattr, m_ca);
        check("char_row", 32'(char_row), 32'(m_row()));
        check("frame_count", 32'(frame_count), 32'(m_fc));
        check("underrun", 32'(underrun), 32'(m_und));
        check("underrun_count", 32'(underrun_count), 32'(m_ucnt));
    endtask

    // The memory side only acks requests the model expects; its data depends on the expected address.
    task automatic cycle(input logic fs, input logic ls, input logic cs, input logic ack,
                         input logic [22:0] base);
        frame_start  = fs;
        line_start   = ls;
        char_strobe  = cs;
        base_address = base;
        mem_ack      = ack && m_req();
        mem_data     = word_for(m_addr());
        @(posedge clk);
        model_step(fs, ls, cs, mem_ack, mem_data, base);
        #1;
        frame_start = 1'b0;
        line_start  = 1'b0;
        char_strobe = 1'b0;
        mem_ack     = 1'b0;
        check_model();
    endtask

    task automatic run_line(input logic chk, input logic [22:0] eaddr, input logic [4:0] erow);
        int guard;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, cur_base);
        if (chk) begin
            check("line_first_addr", 32'(mem_address), 32'(eaddr));
            check("line_char_row", 32'(char_row), 32'(erow));
        end
        guard = 0;
        while (m_acks < COLS && guard < 400) begin
            cycle(1'b0, 1'b0, guard > 0, 1'b1, cur_base);
            guard++;
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, cur_base);
        check("line_done_busy", 32'(busy), 32'd0);
        check("line_done_req", 32'(mem_request), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w100;
        logic [31:0] w101;
        logic [6:0]  e_fc;
        logic        fs;
        logic        ls;
        logic        cs;
        logic        ack;
        int          srate;

        reset        = 1'b1;
        frame_start  = 1'b0;
        line_start   = 1'b0;
        char_strobe  = 1'b0;
        base_address = '0;
        mem_ack      = 1'b0;
        mem_data     = '0;
        cur_base     = 23'h000100;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        check("reset_addr", 32'(mem_address), 32'd0);
        reset = 1'b0;

        // Directed vectors: fetch, pop, underrun, FIFO-full stall and resume, line restart.
        w100 = word_for(23'h100);
        w101 = word_for(23'h101);
        //          fs    ls    cs    ack   req   bsy   en    und   addr       ca     row   fc
        tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 23'h000, 32'h0, 5'd0, 7'd1};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 23'h100, 32'h0, 5'd0, 7'd1};
        tv[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 23'h101, 32'h0, 5'd0, 7'd1};
        tv[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 23'h102, w100,  5'd0, 7'd1};
        tv[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 23'h102, w101,  5'd0, 7'd1};
        tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 23'h102, 32'h0, 5'd0, 7'd1};
        tv[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 23'h102, 32'h0, 5'd0, 7'd1};
        tv[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 23'h000, 32'h0, 5'd0, 7'd2};
        tv[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 23'h100, 32'h0, 5'd0, 7'd2};
        tv[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 23'h101, 32'h0, 5'd0, 7'd2};
        tv[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 23'h102, 32'h0, 5'd0, 7'd2};
        tv[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 23'h103, 32'h0, 5'd0, 7'd2};
        tv[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 23'h000, 32'h0, 5'd0, 7'd2};
        tv[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 23'h000, 32'h0, 5'd0, 7'd2};
        tv[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 23'h104, w100,  5'd0, 7'd2};
        tv[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 23'h100, w100,  5'd1, 7'd2};
        tv[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 23'h100, 32'h0, 5'd1, 7'd2};

        for (int i = 0; i < NV; i++) begin
            cycle(tv[i].fs, tv[i].ls, tv[i].cs, tv[i].ack, 23'h000100);
            check($sformatf("vec%0d_req", i), 32'(mem_request), 32'(tv[i].req));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tv[i].bsy));
            if (tv[i].req) check($sformatf("vec%0d_addr", i), 32'(mem_address), 32'(tv[i].addr));
            check($sformatf("vec%0d_en", i), 32'(enabled), 32'(tv[i].en));
            check($sformatf("vec%0d_ca", i), charattr, tv[i].ca);
            check($sformatf("vec%0d_und", i), 32'(underrun), 32'(tv[i].und));
            check($sformatf("vec%0d_row", i), 32'(char_row), 32'(tv[i].row));
            check($sformatf("vec%0d_fc", i), 32'(frame_count), 32'(tv[i].fc));
        end

        // One full line at full ack rate from base 0x100.
        cur_base = 23'h000100;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, cur_base);
        run_line(1'b1, 23'h000100, 5'd0);

        // 21 lines near the top of the address space: the 21st wraps to base+80 mod 2^23.
        cur_base = 23'h7FFFC0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, cur_base);
        for (int l = 0; l < 21; l++) begin
            run_line(l == 20, 23'h000010, 5'd0);
        end
        e_fc = m_fc + 7'd1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, cur_base);
        check("frame_count_inc", 32'(frame_count), 32'(e_fc));
        run_line(1'b1, 23'h7FFFC0, 5'd0);

        // line_start with an ack pending at col 37: ack dropped, fetch restarts at the row base.
        cur_base = 23'h012345;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, cur_base);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, cur_base);
        for (int k = 0; k < 37; k++) begin
            cycle(1'b0, 1'b0, k > 0, 1'b1, cur_base);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b1, cur_base);
        check("restart_addr", 32'(mem_address), 32'h012345);
        check("restart_row", 32'(char_row), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, cur_base);
        check("restart_no_stale_en", 32'(enabled), 32'd0);
        check("restart_no_stale_ca", charattr, 32'd0);
        check("restart_underrun", 32'(underrun), 32'd1);

        // 300 strobes with nothing fetched.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, cur_base);
        for (int k = 0; k < 300; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, cur_base);
        end
        check("underrun_flag", 32'(underrun), 32'd1);
`ifdef VP_LINE_SCHEDULER_UNDERRUN_COUNT_EN
        check("underrun_count_sat", 32'(underrun_count), 32'd255);
`else
        check("underrun_count_off", 32'(underrun_count), 32'd0);
`endif

        // Simultaneous frame_start+line_start, then reset asserted mid-fetch.
        cur_base = 23'h0ABCDE;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, cur_base);
        check("fs_ls_addr", 32'(mem_address), 32'h0ABCDE);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, cur_base);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, cur_base);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_req", 32'(mem_request), 32'd0);
        check("async_reset_en", 32'(enabled), 32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_model();

        // Random traffic: occasional frames and lines, varying strobe pace and ack rate.
        srate = 50;
        for (int k = 0; k < 3000; k++) begin
            if (k % 500 == 0) srate = int'($urandom_range(20, 90));
            fs  = ($urandom_range(0, 399) == 0);
            ls  = ($urandom_range(0, 69) == 0);
            cs  = ($urandom_range(0, 99) < srate);
            ack = ($urandom_range(0, 3) != 0);
            if (fs) cur_base = 23'($urandom);
            cycle(fs, ls, cs, ack, cur_base);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vp_line_scheduler.md
# vp_line_scheduler

Sequencer that feeds the video pipeline's character input. It walks text rows and glyph rows across a frame, fetches the COLUMNS character/attribute words of the current text row from video memory through a request/acknowledge port, and buffers them in a small FIFO. It then presents one word per character slot to the pipeline's `charattr`, `char_row_in`, `frame_count` and `enabled` inputs.

## Interface
- `COLUMNS`, 80: character words fetched per scanline.
- `CHAR_HEIGHT`, 20: glyph rows per text row.
- `FIFO_DEPTH`, 4: buffered words; power of two, ≥2.
- `clk`  in  1  pixel-domain clock.
- `reset`  in  1  asynchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse at the first scanline of a frame.
- `line_start`  in  1  one-cycle pulse at the start of each active scanline.
- `char_strobe`  in  1  one-cycle pulse per character slot (pipeline consume).
- `base_address`  in  23  word address of the top-left character; sampled on `frame_start`.
- `mem_request`  out  1  read request.
- `mem_address`  out  23  read word address; stable while `mem_request` is high.
- `mem_ack`  in  1  `mem_data` valid, request complete.
- `mem_data`  in  32  charattr word.
- `charattr`  out  32  word to the pipeline.
- `char_row`  out  5  glyph row for the current scanline.
- `frame_count`  out  7  frame counter (blink timing).
- `enabled`  out  1  `charattr` valid this cycle.
- `busy`  out  1  line fetch in progress.
- `underrun`  out  1  sticky: a strobe found the FIFO empty; cleared on `frame_start`.
- `underrun_count`  out  8  saturating underrun count (see Configuration).

## Operation
- Registers:
  - `row_addr` (23 b): address of the current text row.
  - `char_row` (5 b).
  - `col` (7 b): words requested this line.
  - `frame_count` (7 b).
  - FIFO with count.
- `frame_start`:
  - `row_addr` ← `base_address`, `char_row` ← 0, `frame_count` ← `frame_count`+1 (wraps 127→0).
  - `underrun` and `underrun_count` ← 0.
  - Aborts any fetch: returns to IDLE and flushes the FIFO.
- `line_start`:
  - Flushes the FIFO, `col` ← 0, enters REQ.
  - If the previous line had `char_row` = CHAR_HEIGHT−1: `char_row` ← 0 and `row_addr` ← `row_addr`+COLUMNS (mod 2^23).
  - Otherwise `char_row` ← `char_row`+1.
  - The first `line_start` after `frame_start` does not advance; it uses row 0, glyph row 0.
- States:
  - IDLE: `mem_request`=0. Goes to REQ on `line_start`.
  - REQ: `mem_request`=1, `mem_address`=`row_addr`+`col`.
    - On `mem_ack`: push `mem_data`, `col`+1.
    - If `col`+1 = COLUMNS → IDLE.
    - Else if FIFO would be full → WAIT.
    - Else stay in REQ.
  - WAIT: `mem_request`=0. Goes to REQ when the FIFO count < FIFO_DEPTH.
- One outstanding request at a time. The request is never withdrawn before `mem_ack` except by `frame_start`, `line_start` or `reset`.
- `busy` = (state ≠ IDLE).
- `char_strobe`:
  - FIFO non-empty: pop the word into `charattr`, `enabled` ← 1.
  - FIFO empty: `charattr` ← 0, `enabled` ← 0, `underrun` ← 1.
  - Without a strobe, `enabled` ← 0 and `charattr` holds its value.
- Simultaneous events:
  - `frame_start`+`line_start`: frame action first, then the line fetch starts at row 0, glyph 0.
  - Push+pop in the same cycle: FIFO count unchanged; a full FIFO still accepts the push.
  - `mem_ack` in the same cycle as `line_start`: the acknowledged data is discarded.

## Timing
- Reset values: all outputs 0; state IDLE; FIFO empty; `row_addr`, `col`, `char_row` = 0.
- `mem_request` rises the cycle after `line_start`.
- Back-to-back acks sustain one word per cycle.
- `charattr`/`enabled` are registered: valid 1 cycle after `char_strobe`.
- Minimum line time is COLUMNS acks plus 1 cycle; the strobe pace must not outrun the fetch rate, otherwise underrun is flagged.
- `reset` mid-fetch drops `mem_request` immediately (asynchronously).

## Configuration
- `VP_LINE_SCHEDULER_UNDERRUN_COUNT_EN`:
  - Defined: `underrun_count` increments on each underrun strobe, saturates at 255, clears on `frame_start`/`reset`.
  - Undefined: `underrun_count` is constant 0 and no counter logic is built.
  - `underrun` behaves identically in both cases.

## Test plan
- Reset, then `frame_start` with base 0x000100, `line_start`, ack every cycle → addresses 0x100..0x14F, `busy` falls after the 80th ack, `char_row`=0.
- No strobes, ack every cycle → after FIFO_DEPTH acks the state is WAIT with `mem_request`=0; one strobe → the request resumes next cycle at address base+4.
- 21 `line_start`s, CHAR_HEIGHT=20 → the 21st line fetches from base+80 with `char_row`=0; `frame_start` → next line from base, `frame_count`+1.
- `char_strobe` with the FIFO empty → `enabled`=0, `charattr`=0, `underrun`=1; with the macro defined, 300 underruns give `underrun_count`=255.
- `line_start` mid-fetch (col=37, ack pending) → FIFO flushed, next `mem_address` = `row_addr`(new)+0, no stale word output.
- Assert `reset` during REQ → `mem_request`, `enabled`, `busy` go to 0 the same cycle; `frame_count`=0 after release.
